// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between the fetch/data requesters, the arbiter and the shared memory port
//
// Signals (W = address/data width):
//   if_req, if_addr            fetch read request and address
//   if_ack, if_rdata           fetch one-cycle completion pulse and read data
//   d_req, d_we, d_addr,       load/store request, write enable, address,
//   d_wdata, d_be              write data and byte enables
//   d_ack, d_rdata             load/store completion pulse and read data
//   mem_req, mem_we, mem_addr, shared memory request and its fields
//   mem_wdata, mem_be
//   mem_gnt                    memory accepted the request
//   mem_rvalid, mem_rdata      memory response strobe and read data
// Modports:
//   master - the arbiter: consumes requester and memory inputs, drives acks and the memory request
//   slave  - the environment: requesters plus memory
interface mem_port_arbiter_if #(
  parameter int W = 32
);
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_ack;
  logic [W-1:0] if_rdata;

  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [3:0]   d_be;
  logic         d_ack;
  logic [W-1:0] d_rdata;

  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter (fetch, load/store) onto one single-port memory
//
// Ports:
//   main_clk  clock, all state changes on its rising edge
//   rst       synchronous active-low reset
//   bus       mem_port_arbiter_if.master: requester handshakes and the shared memory request
//   busy      high whenever the arbiter is not idle
//
// One transaction is in flight at a time: IDLE picks a winner and latches its
// fields, ISSUE presents mem_req until mem_gnt, WAIT takes the mem_rvalid
// response, RESP pulses the owner's ack for one cycle. Under contention the
// owner alternates, starting with the data port after reset.
module mem_port_arbiter #(
  parameter int W = 32
) (
  input  logic                  main_clk,
  input  logic                  rst,
  mem_port_arbiter_if.master    bus,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t       state_q;
  state_t       state_d;

  logic         owner_q;
  logic         last_owner_q;
  logic         we_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic [3:0]   be_q;
  logic [W-1:0] if_rdata_q;
  logic [W-1:0] d_rdata_q;

  logic         any_req;
  logic         grant_data;

  // Data wins a tie unless it owned the previous transaction.
  always_comb begin
    any_req    = bus.if_req | bus.d_req;
    grant_data = bus.d_req & (~bus.if_req | (last_owner_q == OWN_FETCH));
  end

  always_ff @(posedge main_clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mem_gnt only matters in ISSUE and mem_rvalid only in WAIT, so a response
  // arriving together with the grant is dropped and stray strobes are harmless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req)        state_d = ST_ISSUE;
      ST_ISSUE: if (bus.mem_gnt)    state_d = ST_WAIT;
      ST_WAIT:  if (bus.mem_rvalid) state_d = ST_RESP;
      ST_RESP:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Requests are only looked at in IDLE; RESP returns straight to IDLE so a
  // requester dropping req at the end of its ack is never issued twice.
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && any_req) begin
        owner_q <= grant_data;
        if (grant_data) begin
          we_q    <= bus.d_we;
          addr_q  <= bus.d_addr;
          wdata_q <= bus.d_wdata;
          be_q    <= bus.d_be;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= bus.if_addr;
          wdata_q <= '0;
          be_q    <= 4'b1111;
        end
      end

      // Write responses carry no data; rdata keeps the last read value.
      if (state_q == ST_WAIT && bus.mem_rvalid && !we_q) begin
        if (owner_q == OWN_DATA) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= bus.mem_rdata;
        end
      end

      if (state_q == ST_RESP) begin
        last_owner_q <= owner_q;
      end
    end
  end

  assign bus.mem_req   = (state_q == ST_ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  assign bus.if_ack    = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
  assign bus.d_ack     = (state_q == ST_RESP) && (owner_q == OWN_DATA);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic busy;

  int n_tests;
  int n_fail;
  int cur_vec;

  mem_port_arbiter_if #(.W(32)) bus ();

  mem_port_arbiter #(.W(32)) dut (
    .main_clk (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    int          gnt_delay;
    logic        gnt_rv;
    logic [31:0] rdata;
    logic        exp_data;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'h0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 32'h0;
    bus.d_wdata    = 32'h0;
    bus.d_be       = 4'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called just after a negedge with the arbiter in IDLE.
  task automatic run_vec(input vec_t v);
    logic own_ack;
    logic oth_ack;
    bus.if_req     = v.if_req;
    bus.if_addr    = v.if_addr;
    bus.d_req      = v.d_req;
    bus.d_we       = v.d_we;
    bus.d_addr     = v.d_addr;
    bus.d_wdata    = v.d_wdata;
    bus.d_be       = v.d_be;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hFFFF0000;
    check("idle_busy", busy, 1'b0);

    @(negedge clk);
    check("issue_req",   bus.mem_req,   1'b1);
    check("issue_we",    bus.mem_we,    v.exp_we);
    check("issue_addr",  bus.mem_addr,  v.exp_addr);
    check("issue_wdata", bus.mem_wdata, v.exp_wdata);
    check("issue_be",    bus.mem_be,    v.exp_be);
    check("issue_acks",  {bus.if_ack, bus.d_ack}, 2'b00);
    for (int k = 0; k < v.gnt_delay; k++) begin
      @(negedge clk);
      check("hold_req",   bus.mem_req,  1'b1);
      check("hold_addr",  bus.mem_addr, v.exp_addr);
      check("hold_wdata", bus.mem_wdata, v.exp_wdata);
    end
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = v.gnt_rv;

    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("wait_req",  bus.mem_req, 1'b0);
    check("wait_acks", {bus.if_ack, bus.d_ack}, 2'b00);
    if (v.gnt_rv) begin
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      check("wait_hold_acks", {bus.if_ack, bus.d_ack}, 2'b00);
      check("wait_hold_busy", busy, 1'b1);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = v.rdata;

    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hFFFF0000;
    own_ack = v.exp_data ? bus.d_ack : bus.if_ack;
    oth_ack = v.exp_data ? bus.if_ack : bus.d_ack;
    check("resp_own_ack",   own_ack, 1'b1);
    check("resp_other_ack", oth_ack, 1'b0);
    check("resp_busy",      busy,    1'b1);
    if (v.exp_data) bus.d_req = 1'b0;
    else            bus.if_req = 1'b0;

    @(negedge clk);
    check("post_acks",  {bus.if_ack, bus.d_ack}, 2'b00);
    check("post_busy",  busy, 1'b0);
    check("if_rdata",   bus.if_rdata, v.exp_if_rdata);
    check("d_rdata",    bus.d_rdata,  v.exp_d_rdata);
  endtask

  initial begin
    logic [3:0] exp_order;
    int         nack;
    logic       prev;

    n_tests = 0;
    n_fail  = 0;
    cur_vec = -1;

    //          if_req if_addr       d_req d_we  d_addr      d_wdata        d_be     dly rv    rdata           data  we    addr          wdata          be       if_rdata        d_rdata
    vecs[0] = '{1'b1, 32'h00003000, 1'b0, 1'b0, 32'h0,      32'h0,         4'h0,    0, 1'b0, 32'h24020005, 1'b0, 1'b0, 32'h00003000, 32'h0,         4'hF,    32'h24020005, 32'h0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,     32'hDEADBEEF,  4'b0011, 0, 1'b0, 32'h55555555, 1'b1, 1'b1, 32'h10,       32'hDEADBEEF,  4'b0011, 32'h24020005, 32'h0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h20,     32'h0,         4'hF,    5, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h20,       32'h0,         4'hF,    32'h24020005, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 32'h00003004, 1'b1, 1'b0, 32'h40,     32'h0,         4'hF,    0, 1'b0, 32'h11112222, 1'b0, 1'b0, 32'h00003004, 32'h0,         4'hF,    32'h11112222, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h40,     32'h0,         4'hF,    0, 1'b1, 32'h0BADC0DE, 1'b1, 1'b0, 32'h40,       32'h0,         4'hF,    32'h11112222, 32'h0BADC0DE};
    vecs[5] = '{1'b1, 32'h00003008, 1'b1, 1'b1, 32'h44,     32'h12345678,  4'b1100, 0, 1'b0, 32'h33334444, 1'b0, 1'b0, 32'h00003008, 32'h0,         4'hF,    32'h33334444, 32'h0BADC0DE};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h44,     32'h12345678,  4'b1100, 1, 1'b0, 32'hAAAA5555, 1'b1, 1'b1, 32'h44,       32'h12345678,  4'b1100, 32'h33334444, 32'h0BADC0DE};
    vecs[7] = '{1'b1, 32'h0000300C, 1'b0, 1'b0, 32'h0,      32'h0,         4'h0,    2, 1'b0, 32'h77778888, 1'b0, 1'b0, 32'h0000300C, 32'h0,         4'hF,    32'h77778888, 32'h0BADC0DE};
    vecs[8] = '{1'b1, 32'h00003010, 1'b1, 1'b0, 32'h50,     32'h0,         4'hF,    0, 1'b0, 32'h9999AAAA, 1'b1, 1'b0, 32'h50,       32'h0,         4'hF,    32'h77778888, 32'h9999AAAA};

    // Reset state, sampled while rst is still low.
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req",   bus.mem_req,   1'b0);
    check("rst_mem_we",    bus.mem_we,    1'b0);
    check("rst_mem_addr",  bus.mem_addr,  32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be",    bus.mem_be,    4'h0);
    check("rst_acks",      {bus.if_ack, bus.d_ack}, 2'b00);
    check("rst_if_rdata",  bus.if_rdata,  32'h0);
    check("rst_d_rdata",   bus.d_rdata,   32'h0);
    check("rst_busy",      busy,          1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Spurious strobes in IDLE with no request.
    cur_vec = 100;
    bus.if_req     = 1'b0;
    bus.d_req      = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("spur_busy",     busy,          1'b0);
      check("spur_mem_req",  bus.mem_req,   1'b0);
      check("spur_mem_addr", bus.mem_addr,  32'h50);
      check("spur_acks",     {bus.if_ack, bus.d_ack}, 2'b00);
      check("spur_if_rdata", bus.if_rdata,  32'h77778888);
      check("spur_d_rdata",  bus.d_rdata,   32'h9999AAAA);
    end

    // Contention from reset with both requests and both memory strobes held high.
    cur_vec = 101;
    do_reset();
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h00004000;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_addr     = 32'h80;
    bus.d_be       = 4'hF;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h600D0000;
    exp_order = 4'b0101;
    nack = 0;
    prev = 1'b0;
    for (int c = 0; c < 24 && nack < 4; c++) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) begin
        check("cont_both_acks", {bus.if_ack, bus.d_ack} == 2'b11, 1'b0);
        check("cont_owner",     bus.d_ack, exp_order[nack]);
        check("cont_ack_width", prev, 1'b0);
        nack++;
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
    check("cont_count", nack, 4);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    check("cont_last_width", {bus.if_ack, bus.d_ack}, 2'b00);
    check("cont_if_rdata",   bus.if_rdata, 32'h600D0000);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset while waiting for the response, then a stray rvalid.
    cur_vec = 102;
    do_reset();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h90;
    bus.d_be   = 4'hF;
    @(negedge clk);
    check("rw_issue", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("rw_wait_busy", busy, 1'b1);
    rst        = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    rst            = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    check("rw_rst_busy", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rw_acks",    {bus.if_ack, bus.d_ack}, 2'b00);
      check("rw_busy",    busy, 1'b0);
      check("rw_mem_req", bus.mem_req, 1'b0);
      check("rw_d_rdata", bus.d_rdata, 32'h0);
    end
    bus.mem_rvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width for addresses and data.
REQ-002 SHALL have port main_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low (rst == 0 sampled at a main_clk edge resets).
REQ-004 SHALL have ports if_req (in, 1), if_addr (in, W), if_ack (out, 1), if_rdata (out, W): the instruction-fetch read requester.
REQ-005 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, W), d_wdata (in, W), d_be (in, 4), d_ack (out, 1), d_rdata (out, W): the load/store requester.
REQ-006 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, W), mem_wdata (out, W), mem_be (out, 4): the shared single-port memory request.
REQ-007 SHALL have ports mem_gnt (in, 1), mem_rvalid (in, 1), mem_rdata (in, W): memory accept strobe, response strobe (reads and writes), and read data.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one state per cycle.
REQ-010 IDLE: if any req is high, SHALL latch the winner's address, we, wdata, and be into registers, record owner, and go to ISSUE; else stay in IDLE.
REQ-011 Arbitration SHALL be: only one req high -> that one wins; both high -> data wins unless last_owner == data, in which case fetch wins.
REQ-012 A fetch grant SHALL drive the latched mem_we = 0 and mem_be = 4'b1111.
REQ-013 ISSUE: mem_req SHALL be 1 with all mem_* fields driven from registers and stable; go to WAIT on the cycle mem_gnt == 1 is sampled, else hold.
REQ-014 mem_req SHALL be 0 in IDLE, WAIT, and RESP.
REQ-015 WAIT: on mem_rvalid == 1, SHALL register mem_rdata into the owner's rdata (reads only) and go to RESP.
REQ-016 RESP: the owner's ack SHALL be 1 for exactly this one cycle; the other ack SHALL be 0; last_owner <= owner; next state IDLE.
REQ-017 Requests SHALL NOT be sampled in RESP, so a requester deasserting req at the edge that ends RESP is never double-issued.
REQ-018 A requester SHALL hold req and its fields constant until its ack; the arbiter samples fields only in IDLE.
REQ-019 Minimum latency SHALL be 4 cycles from req sampled in IDLE to ack: IDLE, ISSUE with mem_gnt = 1, WAIT with immediate mem_rvalid, RESP.
REQ-020 A write response SHALL leave d_rdata unchanged.
REQ-021 if_rdata and d_rdata SHALL hold their last value until overwritten by that requester's next read.
REQ-022 mem_gnt outside ISSUE and mem_rvalid outside WAIT SHALL be ignored with no state change.
REQ-023 mem_gnt and mem_rvalid both high in ISSUE SHALL go to WAIT only; the rvalid is ignored.
REQ-024 The losing requester SHALL keep waiting with no lost request; back-to-back contention SHALL alternate owners, with no starvation.

Reset
REQ-025 On rst == 0 the block SHALL go to IDLE with mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, if_ack = 0, d_ack = 0, if_rdata = 0, d_rdata = 0, busy = 0, and last_owner = fetch.
REQ-026 Reset in any state SHALL abandon the in-flight transaction with no ack, and its late mem_rvalid SHALL be ignored per REQ-022.

Verification
REQ-027 Fetch only: if_req = 1 with if_addr = 0x00003000, mem_gnt = 1 on the first ISSUE cycle, mem_rvalid = 1 next cycle with mem_rdata = 0x24020005 -> mem_addr = 0x00003000, mem_we = 0, if_ack pulses once 4 cycles after the request is sampled, if_rdata = 0x24020005.
REQ-028 Store: d_req = 1, d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF, d_be = 4'b0011 -> mem_we = 1, mem_be = 4'b0011, mem_wdata = 0xDEADBEEF, d_ack pulses once, d_rdata unchanged.
REQ-029 Contention from reset: if_req and d_req both high continuously -> grant order data, fetch, data, fetch, with each ack 1 cycle wide.
REQ-030 Backpressure: mem_gnt held low for 5 ISSUE cycles -> mem_req high and mem_addr stable for all 6 cycles, then normal completion.
REQ-031 Reset mid-WAIT: rst = 0 for 1 cycle, then stray mem_rvalid = 1 -> no ack, state IDLE, busy = 0.
REQ-032 Spurious strobes: mem_rvalid = 1 and mem_gnt = 1 in IDLE with no req -> state stays IDLE, outputs unchanged.
